// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Front-end for the PWM mode selector. Synchronises and debounces two raw
//   active-low push-buttons, produces per-key press/release pulses and keeps
//   a one-hot mode register that drives the PWM generator's mode inputs.
//
// Ports
//   clk          system clock; every output is registered on its rising edge
//   rst_n        asynchronous active-low reset
//   key0_n       raw push-button 0, active-low, asynchronous, bouncing
//   key1_n       raw push-button 1, active-low, asynchronous, bouncing
//   key_level    debounced level per key, active-high pressed
//   key_press    one-clock pulse per accepted press, per key
//   key_release  one-clock pulse per accepted release, per key
//   mode         one-hot mode: 2'b01 = mode A (50 Hz), 2'b10 = mode B (60 Hz)
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key0_n,
    input  logic       key1_n,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] mode
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    // Two-flop synchronisers; reset to 1 so a key reads as released.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] key_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= {key1_n, key0_n};
            sync_q <= meta_q;
        end
    end

    assign key_sync = ~sync_q;

    state_e          state_q [2];
    state_e          state_d [2];
    logic [CW-1:0]   cnt_q   [2];
    logic [CW-1:0]   cnt_d   [2];
    logic [1:0]      level_q, level_d;
    logic [1:0]      press_q, press_d;
    logic [1:0]      release_q, release_d;
    logic [1:0]      mode_q, mode_d;

    // Per-key debounce FSM. The counter is cleared on every state entry, so
    // any disagreeing sample restarts qualification from scratch. The
    // transition is taken on the edge where the counter would reach
    // DEBOUNCE_CYCLES, i.e. after DEBOUNCE_CYCLES consecutive agreeing samples.
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            level_d[k]   = level_q[k];
            press_d[k]   = 1'b0;
            release_d[k] = 1'b0;
            case (state_q[k])
                IDLE: begin
                    if (key_sync[k]) begin
                        state_d[k] = PRESS_WAIT;
                        cnt_d[k]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_sync[k]) begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] + CNT_ONE == CNT_DONE) begin
                        state_d[k] = HELD;
                        cnt_d[k]   = '0;
                        level_d[k] = 1'b1;
                        press_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!key_sync[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        cnt_d[k]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_sync[k]) begin
                        state_d[k] = HELD;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] + CNT_ONE == CNT_DONE) begin
                        state_d[k]   = IDLE;
                        cnt_d[k]     = '0;
                        level_d[k]   = 1'b0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    cnt_d[k]   = '0;
                    level_d[k] = 1'b0;
                end
            endcase
        end
    end

    // Mode follows a single-key press one clock after its pulse; a
    // simultaneous press (2'b11) is ambiguous and leaves the mode alone.
    always_comb begin
        mode_d = mode_q;
        case (press_q)
            2'b01:   mode_d = 2'b01;
            2'b10:   mode_d = 2'b10;
            default: mode_d = mode_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            mode_q    <= 2'b01;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            mode_q    <= mode_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign mode        = mode_q;

endmodule
